// File: rtl/rv32i_types.sv
// Shared RV32I datapath types, plus the state encoding for the memory alignment bridge.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_bridge_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Moves a low-justified store mask/data into byte lanes and flags illegal mask/offset pairs.
module mem_lane_align
  import rv32i_types::*;
(
  input  rv32i_mem_wmask mask,
  input  rv32i_word      data,
  input  logic [1:0]     off,
  output rv32i_mem_wmask mask_shifted,
  output rv32i_word      data_shifted,
  output logic           misaligned
);

  always_comb begin
    mask_shifted = mask << off;
    data_shifted = data << {off, 3'b000};
    // Only byte, naturally aligned half and aligned word are legal; any other mask is rejected.
    case (mask)
      4'b0001: misaligned = 1'b0;
      4'b0011: misaligned = off[0];
      4'b1111: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_align_bridge.sv
// Registers CPU memory requests and re-issues them as word-aligned physical accesses.
//   state | meaning
//   IDLE  | waiting for mem_read / mem_write
//   BUSY  | pmem strobe held, waiting for pmem_resp
//   RESP  | one-cycle mem_resp (mem_misaligned set for rejected accesses)
module mem_align_bridge
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst,
  input  rv32i_word      mem_address,
  input  logic           mem_read,
  input  logic           mem_write,
  input  rv32i_mem_wmask mem_byte_enable,
  input  rv32i_word      mem_wdata,
  output rv32i_word      mem_rdata,
  output logic           mem_resp,
  output logic           mem_misaligned,
  output rv32i_word      pmem_address,
  output logic           pmem_read,
  output logic           pmem_write,
  output rv32i_mem_wmask pmem_byte_enable,
  output rv32i_word      pmem_wdata,
  input  rv32i_word      pmem_rdata,
  input  logic           pmem_resp
);

  mem_bridge_state_t state;
  rv32i_mem_wmask    mask_shifted;
  rv32i_word         data_shifted;
  logic              misaligned;

  mem_lane_align u_lane_align (
    .mask         (mem_byte_enable),
    .data         (mem_wdata),
    .off          (mem_address[1:0]),
    .mask_shifted (mask_shifted),
    .data_shifted (data_shifted),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mem_rdata        <= '0;
      mem_resp         <= 1'b0;
      mem_misaligned   <= 1'b0;
      pmem_address     <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= '0;
      pmem_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            if (misaligned) begin
              state          <= RESP;
              mem_resp       <= 1'b1;
              mem_misaligned <= 1'b1;
              mem_rdata      <= '0;
            end else begin
              // Write takes priority; a simultaneous read is dropped.
              state            <= BUSY;
              pmem_address     <= {mem_address[31:2], 2'b00};
              pmem_write       <= mem_write;
              pmem_read        <= !mem_write;
              pmem_byte_enable <= mem_write ? mask_shifted : 4'b1111;
              pmem_wdata       <= mem_write ? data_shifted : '0;
            end
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            if (pmem_read) mem_rdata <= pmem_rdata;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          mem_resp       <= 1'b0;
          mem_misaligned <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_bridge.sv
// Self-checking bench for mem_align_bridge: directed cases plus randomized accesses vs. a byte-lane model.
module tb_mem_align_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_misaligned;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_align_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .mem_misaligned   (mem_misaligned),
    .pmem_address     (pmem_address),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_wdata       (pmem_wdata),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  // Reference: legality from the mask/offset table, lanes placed byte by byte.
  function automatic void model(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                                input logic [31:0] wd, output bit legal,
                                output logic [3:0] ebe, output logic [31:0] ewd);
    int off;
    off   = int'(addr % 4);
    legal = (be == 4'd1) || (be == 4'd3 && off % 2 == 0) || (be == 4'd15 && off == 0);
    ebe   = '0;
    ewd   = '0;
    if (!wr) ebe = 4'hF;
    else
      for (int i = 0; i < 4; i++)
        if (i + off < 4) begin
          if (be[i]) ebe[i+off] = 1'b1;
          ewd[8*(i+off) +: 8] = wd[8*i +: 8];
        end
  endfunction

  // Issues one CPU request, plays a pmem responding lat cycles after its strobe, and
  // observes until the cycle after mem_resp (where the CPU drops its strobe).
  task automatic run_req(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd, input int lat,
                         input logic [31:0] prd,
                         output int resp_cyc, output int strobe_cnt, output int resp_cnt,
                         output logic [31:0] o_addr, output logic [3:0] o_be,
                         output logic [31:0] o_wdata, output logic o_wr,
                         output logic [31:0] o_rdata, output logic o_mis, output bit timeout);
    int first_strobe;
    bit done;
    first_strobe = -1; resp_cyc = -1; strobe_cnt = 0; resp_cnt = 0; timeout = 0; done = 0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_wr = 1'b0; o_rdata = '0; o_mis = 1'b0;
    @(posedge clk); #1;
    mem_address = addr; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (resp_cyc >= 0 && cyc == resp_cyc + 1) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
      if (pmem_read || pmem_write) begin
        strobe_cnt++;
        if (first_strobe < 0) begin
          first_strobe = cyc; o_addr = pmem_address; o_be = pmem_byte_enable;
          o_wdata = pmem_wdata; o_wr = pmem_write;
        end
        if (cyc == first_strobe + lat) begin
          pmem_resp = 1'b1; pmem_rdata = prd;
        end
      end
      if (mem_resp) begin
        resp_cnt++;
        if (resp_cyc < 0) begin
          resp_cyc = cyc; o_rdata = mem_rdata; o_mis = mem_misaligned;
        end
      end
      if (resp_cyc >= 0 && cyc == resp_cyc + 1) done = 1;
    end
    if (!done) begin
      timeout = 1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_rdata, mem_resp, mem_misaligned, pmem_address, pmem_read, pmem_write,
         pmem_byte_enable, pmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdata=%h resp=%b mis=%b paddr=%h prd=%b pwr=%b pbe=%b pwd=%h want all 0",
               mem_rdata, mem_resp, mem_misaligned, pmem_address, pmem_read, pmem_write,
               pmem_byte_enable, pmem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_sb();
    int rc, sc, nc; logic [31:0] a, w, r; logic [3:0] b; logic ow, m; bit to;
    run_req(32'h0000_1002, 1'b0, 1'b1, 4'b0001, 32'h0000_00AB, 2, 32'h0, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL sb_timeout: no mem_resp within 60 cycles"); end
    n_cmp++; if (a !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", a); end
    n_cmp++; if (b !== 4'b0100) begin n_fail++; $display("FAIL sb_be: got %b want 0100", b); end
    n_cmp++; if (w !== 32'h00AB_0000) begin n_fail++; $display("FAIL sb_wdata: got %h want 00ab0000", w); end
    n_cmp++; if (rc != 4) begin n_fail++; $display("FAIL sb_latency: got %0d want 4", rc); end
    n_cmp++; if (nc != 1 || m !== 1'b0) begin n_fail++; $display("FAIL sb_resp: count %0d mis %b want 1/0", nc, m); end
  endtask

  task automatic test_lw();
    int rc, sc, nc; logic [31:0] a, w, r; logic [3:0] b; logic ow, m; bit to;
    run_req(32'h0000_2000, 1'b1, 1'b0, 4'b1111, 32'h0, 3, 32'hDEAD_BEEF, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL lw_timeout: no mem_resp within 60 cycles"); end
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", r); end
    n_cmp++; if (b !== 4'b1111 || ow !== 1'b0) begin n_fail++; $display("FAIL lw_be: got be %b wr %b want 1111/0", b, ow); end
    n_cmp++; if (rc != 5 || nc != 1) begin n_fail++; $display("FAIL lw_resp: latency %0d count %0d want 5/1", rc, nc); end
  endtask

  task automatic test_misaligned();
    int rc, sc, nc; logic [31:0] a, w, r; logic [3:0] b; logic ow, m; bit to;
    run_req(32'h0000_1001, 1'b0, 1'b1, 4'b1111, 32'h1234_5678, 0, 32'h0, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (rc != 1 || m !== 1'b1 || nc != 1) begin n_fail++; $display("FAIL sw_misaligned: latency %0d mis %b count %0d want 1/1/1", rc, m, nc); end
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL sw_misaligned_rdata: got %h want 0", r); end
    n_cmp++; if (sc != 0) begin n_fail++; $display("FAIL sw_misaligned_pmem: strobe cycles %0d want 0", sc); end
    run_req(32'h0000_1003, 1'b0, 1'b1, 4'b0011, 32'h0000_BEEF, 0, 32'h0, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (rc != 1 || m !== 1'b1 || sc != 0) begin n_fail++; $display("FAIL sh_misaligned: latency %0d mis %b strobes %0d want 1/1/0", rc, m, sc); end
  endtask

  task automatic test_sh();
    int rc, sc, nc; logic [31:0] a, w, r; logic [3:0] b; logic ow, m; bit to;
    run_req(32'h0000_1002, 1'b0, 1'b1, 4'b0011, 32'h0000_BEEF, 1, 32'h0, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (b !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", b); end
    n_cmp++; if (w !== 32'hBEEF_0000) begin n_fail++; $display("FAIL sh_wdata: got %h want beef0000", w); end
    n_cmp++; if (rc != 3 || m !== 1'b0) begin n_fail++; $display("FAIL sh_resp: latency %0d mis %b want 3/0", rc, m); end
  endtask

  task automatic test_reset_busy();
    bit bad;
    bad = 0;
    @(posedge clk); #1;
    mem_address = 32'h0000_3004; mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable = 4'b1111;
    @(posedge clk); #1;
    n_cmp++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL rstbusy_strobe: pmem_read %b want 1", pmem_read); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0;
    n_cmp++;
    if ({pmem_read, pmem_write, mem_resp, mem_misaligned, mem_rdata, pmem_address,
         pmem_byte_enable, pmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rstbusy_outputs: prd=%b pwr=%b resp=%b paddr=%h pbe=%b want all 0",
               pmem_read, pmem_write, mem_resp, pmem_address, pmem_byte_enable);
    end
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (mem_resp || pmem_read || pmem_write || mem_rdata != 0) bad = 1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL rstbusy_stray_resp: bridge reacted (got 1 want 0)"); end
  endtask

  task automatic test_back_to_back();
    int rc, sc, nc; logic [31:0] a, w, r; logic [3:0] b; logic ow, m; bit to;
    run_req(32'h0000_0100, 1'b1, 1'b0, 4'b1111, 32'h0, 1, 32'h1111_2222, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (sc != 2 || nc != 1 || r !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_first: strobes %0d resps %0d rdata %h want 2/1/11112222", sc, nc, r); end
    run_req(32'h0000_0104, 1'b1, 1'b0, 4'b1111, 32'h0, 0, 32'h3333_4444, rc, sc, nc, a, b, w, ow, r, m, to);
    n_cmp++; if (sc != 1 || nc != 1 || rc != 2 || r !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_second: strobes %0d resps %0d latency %0d rdata %h want 1/1/2/33334444", sc, nc, rc, r); end
  endtask

  task automatic test_random();
    int rc, sc, nc, lat, op;
    logic [31:0] a, w, r, addr, wd, prd, ewd;
    logic [3:0] b, be, ebe;
    logic ow, m, rd, wr;
    bit to, legal;
    logic [3:0] masks [8] = '{4'd1, 4'd3, 4'd15, 4'd1, 4'd3, 4'd15, 4'd6, 4'd0};
    for (int it = 0; it < 60; it++) begin
      addr = $urandom; wd = $urandom; prd = $urandom;
      be = masks[$urandom_range(0, 7)];
      lat = $urandom_range(0, 4);
      op = $urandom_range(0, 2);
      rd = (op != 1); wr = (op != 0);
      model(addr, wr, be, wd, legal, ebe, ewd);
      run_req(addr, rd, wr, be, wd, lat, prd, rc, sc, nc, a, b, w, ow, r, m, to);
      n_cmp++;
      if (to || nc != 1 || m !== !legal || rc != (legal ? lat + 2 : 1) || sc != (legal ? lat + 1 : 0)) begin
        n_fail++;
        $display("FAIL rand_handshake[%0d]: to=%0d resps=%0d mis=%b lat=%0d strobes=%0d want 0/1/%b/%0d/%0d",
                 it, to, nc, m, rc, sc, !legal, legal ? lat + 2 : 1, legal ? lat + 1 : 0);
      end
      if (legal) begin
        n_cmp++;
        if (a !== {addr[31:2], 2'b00} || b !== ebe || ow !== wr) begin
          n_fail++;
          $display("FAIL rand_pmem[%0d]: addr %h be %b wr %b want %h %b %b", it, a, b, ow, {addr[31:2], 2'b00}, ebe, wr);
        end
        n_cmp++;
        if (wr ? (w !== ewd) : (r !== prd)) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: wdata %h rdata %h want %h", it, w, r, wr ? ewd : prd);
        end
      end else begin
        n_cmp++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL rand_mis_rdata[%0d]: got %h want 0", it, r); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lw();
    test_misaligned();
    test_sh();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
